rom_boot_loader: RTL and testbench
==================================

Name: rom_boot_loader

Overview:
UART-driven boot controller for the risc16f84_clk2x program ROM. It sits between the uart byte streams and the ROM write port. It parses a framed download, writes 14-bit words into program ROM and holds the CPU in reset for the whole transfer. It returns an ACK/NAK byte and releases the CPU only after a good checksum.

Parameters:
ROM_ADDR_WIDTH, 12, program ROM address width; maximum load is 1<<ROM_ADDR_WIDTH words
ROM_DATA_WIDTH, 14, program word width
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame
SYNC_BYTE, 8'hA5, frame start marker
ACK_BYTE, 8'h06, success response
NAK_BYTE, 8'h15, failure response

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
rx_tdata  in  8  byte from uart output_axis
rx_tvalid  in  1  byte valid
rx_tready  out  1  loader accepts byte
tx_tdata  out  8  response byte to uart input_axis
tx_tvalid  out  1  response valid
tx_tready  in  1  uart accepts response
rom_adr_o  out  ROM_ADDR_WIDTH  ROM write address
rom_dat_o  out  ROM_DATA_WIDTH  ROM write data
rom_we_o  out  1  one-cycle ROM write strobe
cpu_reset_o  out  1  active-high CPU reset, drives risc16f84 reset_i (OR'd with ~reset_n at top)
busy_o  out  1  frame in progress
err_o  out  1  sticky: last frame failed

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous, active-low.
- Reset values: state=IDLE. rx_tready=1. tx_tvalid=0. tx_tdata=0. rom_we_o=0. rom_adr_o=0. rom_dat_o=0. cpu_reset_o=0. busy_o=0. err_o=0. Word count, address, checksum and timeout counter are all 0.
- A byte is accepted when rx_tvalid&&rx_tready. rx_tready=1 in IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK. It is 0 in WRITE and RESP.
- Frame format: SYNC, LEN_HI, LEN_LO (word count N, big-endian), N×{DAT_HI, DAT_LO}, CHK.
- Checksum: an 8-bit running sum of every byte after SYNC, including CHK. The frame is good when the sum is 8'h00.
- IDLE:
  - A byte equal to SYNC_BYTE: cpu_reset_o<=1, busy_o<=1, sum<=0, addr<=0, go to LEN_HI.
  - Any other byte is dropped and the state stays IDLE.
- LEN_HI → LEN_LO: latch the high byte.
- LEN_LO: latch N (ROM_ADDR_WIDTH+1 bits, upper bits truncated from 16).
  - If the 16-bit N is 0 or greater than 1<<ROM_ADDR_WIDTH, go to RESP with NAK.
  - Otherwise go to DAT_HI.
- DAT_HI → DAT_LO: latch the byte.
- DAT_LO:
  - rom_dat_o<={hi[ROM_DATA_WIDTH-9:0],lo}. Hi bits above the word width are ignored but still summed.
  - Go to WRITE.
- WRITE (1 cycle):
  - rom_we_o=1 with rom_adr_o=addr.
  - Then addr++ and N--.
  - If N reaches 0, go to CHK; else go to DAT_HI.
- Ordering: ROM writes happen before the checksum is known. A failed frame leaves the ROM partially overwritten, and the CPU stays held.
- CHK: accept one byte.
  - If the final sum is 0: tx_tdata=ACK_BYTE and err_o<=0.
  - Else: tx_tdata=NAK_BYTE and err_o<=1.
  - Go to RESP.
- RESP:
  - tx_tvalid=1 with tx_tdata stable until tx_tready.
  - On handshake: tx_tvalid<=0, busy_o<=0, go to IDLE.
  - cpu_reset_o<=0 only if ACK was sent. After NAK, cpu_reset_o stays 1 until a later ACK.
- Timeout:
  - The counter clears on every accepted byte and counts each cycle in LEN_HI..CHK.
  - When it reaches TIMEOUT_CYCLES-1, go to RESP with NAK and err_o<=1.
  - It is not active in IDLE, WRITE or RESP.
- Simultaneous events: a byte accepted in the same cycle the timeout would fire wins; the counter clears.
- Reset mid-frame: all state returns to reset values. cpu_reset_o=0, so the CPU runs whatever the ROM now holds.

Decomposition:
- Package rom_boot_pkg holds:
  - the state enum: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, RESP;
  - the SYNC/ACK/NAK constants;
  - a function for timeout counter width, $clog2(TIMEOUT_CYCLES).
- Sub-module: boot_timeout_ctr (load/clear/expire counter). Everything else stays in one FSM module.

Test Plan:
- Good 2-word load: bytes A5,00,02,12,34,05,67, then CHK=0x100-(0x00+0x02+0x12+0x34+0x05+0x67) → CHK=0x4C.
  - ROM[0]=0x1234, ROM[1]=0x0567, two single-cycle rom_we_o pulses.
  - tx 0x06; cpu_reset_o 1→0 after the tx handshake; err_o=0.
- Bad checksum: same frame with CHK=0x00.
  - Both writes occur; tx 0x15; err_o=1; cpu_reset_o remains 1.
  - A following good frame gives ACK and cpu_reset_o=0.
- Length errors: A5,00,00 → immediate NAK, no rom_we_o. A5,10,01 (N=4097 > 4096) → NAK, no writes.
- Timeout: A5,00,01,3F, then silence for TIMEOUT_CYCLES (set to 50).
  - NAK is sent at cycle 50 after the last byte; err_o=1.
- Backpressure and noise:
  - Hold tx_tready=0 for 20 cycles in RESP: tx_tvalid and tx_tdata stay stable, rx_tready=0.
  - Garbage bytes 00,FF in IDLE are ignored, with no change to cpu_reset_o.
- Reset mid-frame: assert reset_n=0 during DAT_LO.
  - Next cycle all outputs are at reset values and the state is IDLE.

Source files
------------

// File: rtl/rom_boot_loader_pkg.sv
// Shared types and constants for the UART-driven program ROM boot loader.
package rom_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    CHK,
    RESP
  } boot_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

  function automatic int tmo_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Byte-stream handshake between the UART and the boot loader (rx in, tx response out).
interface rom_boot_loader_if;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;

  modport master (
    output rx_tdata, rx_tvalid, tx_tready,
    input  rx_tready, tx_tdata, tx_tvalid
  );

  modport slave (
    input  rx_tdata, rx_tvalid, tx_tready,
    output rx_tready, tx_tdata, tx_tvalid
  );
endinterface

// File: rtl/rom_boot_loader_timeout_ctr.sv
// Inter-byte idle timer: clears on request, counts while enabled, flags the terminal count.
module boot_timeout_ctr
  import rom_boot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);
endmodule

// File: rtl/rom_boot_loader.sv
// Boot loader FSM: parses SYNC/LEN/DATA/CHK frames, writes program ROM, holds the CPU in reset.
// IDLE wait sync | LEN_* word count | DAT_* word bytes | WRITE rom strobe | CHK checksum | RESP reply
module rom_boot_loader
  import rom_boot_pkg::*;
#(
  parameter int         ROM_ADDR_WIDTH = 12,
  parameter int         ROM_DATA_WIDTH = 14,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  rom_boot_loader_if.slave          bus,
  output logic [ROM_ADDR_WIDTH-1:0] rom_adr_o,
  output logic [ROM_DATA_WIDTH-1:0] rom_dat_o,
  output logic                      rom_we_o,
  output logic                      cpu_reset_o,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int NW = ROM_ADDR_WIDTH + 1;
  localparam int HW = ROM_DATA_WIDTH - 8;
  localparam logic [16:0] MAX_LEN = 17'(1) << ROM_ADDR_WIDTH;

  boot_state_t               r_state;
  logic                      r_rx_tready;
  logic                      r_tx_tvalid;
  logic [7:0]                r_tx_tdata;
  logic                      r_rom_we;
  logic [ROM_ADDR_WIDTH-1:0] r_rom_adr;
  logic [ROM_DATA_WIDTH-1:0] r_rom_dat;
  logic                      r_cpu_reset;
  logic                      r_busy;
  logic                      r_err;
  logic [7:0]                r_len_hi;
  logic [7:0]                r_sum;
  logic [HW-1:0]             r_dat_hi;
  logic [NW-1:0]             r_cnt;
  logic [ROM_ADDR_WIDTH-1:0] r_addr;

  logic       w_accept;
  logic       w_active;
  logic       w_expire;
  logic       w_timeout;
  logic       w_len_bad;
  logic [7:0] w_sum_next;
  logic [15:0] w_len16;

  assign w_accept   = bus.rx_tvalid && r_rx_tready;
  assign w_active   = r_state inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK};
  assign w_sum_next = r_sum + bus.rx_tdata;
  assign w_len16    = {r_len_hi, bus.rx_tdata};
  assign w_len_bad  = (w_len16 == 16'd0) || ({1'b0, w_len16} > MAX_LEN);
  // An accepted byte beats a timeout landing in the same cycle.
  assign w_timeout  = w_expire && !w_accept;

  boot_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_accept || !w_active),
    .i_en    (w_active),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rx_tready <= 1'b1;
      r_tx_tvalid <= 1'b0;
      r_tx_tdata  <= '0;
      r_rom_we    <= 1'b0;
      r_rom_adr   <= '0;
      r_rom_dat   <= '0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_len_hi    <= '0;
      r_sum       <= '0;
      r_dat_hi    <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
    end else begin
      r_rom_we <= 1'b0;
      if (w_timeout) begin
        r_state     <= RESP;
        r_tx_tdata  <= NAK_BYTE;
        r_tx_tvalid <= 1'b1;
        r_err       <= 1'b1;
        r_rx_tready <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept && (bus.rx_tdata == SYNC_BYTE)) begin
              r_cpu_reset <= 1'b1;
              r_busy      <= 1'b1;
              r_sum       <= '0;
              r_addr      <= '0;
              r_state     <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (w_accept) begin
              r_len_hi <= bus.rx_tdata;
              r_sum    <= w_sum_next;
              r_state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (w_accept) begin
              r_sum <= w_sum_next;
              if (w_len_bad) begin
                r_state     <= RESP;
                r_tx_tdata  <= NAK_BYTE;
                r_tx_tvalid <= 1'b1;
                r_err       <= 1'b1;
                r_rx_tready <= 1'b0;
              end else begin
                r_cnt   <= w_len16[NW-1:0];
                r_state <= DAT_HI;
              end
            end
          end
          DAT_HI: begin
            if (w_accept) begin
              r_dat_hi <= bus.rx_tdata[HW-1:0];
              r_sum    <= w_sum_next;
              r_state  <= DAT_LO;
            end
          end
          DAT_LO: begin
            if (w_accept) begin
              r_sum       <= w_sum_next;
              r_rom_dat   <= {r_dat_hi, bus.rx_tdata};
              r_rom_adr   <= r_addr;
              r_rom_we    <= 1'b1;
              r_rx_tready <= 1'b0;
              r_state     <= WRITE;
            end
          end
          WRITE: begin
            r_addr      <= r_addr + ROM_ADDR_WIDTH'(1);
            r_cnt       <= r_cnt - NW'(1);
            r_rx_tready <= 1'b1;
            r_state     <= (r_cnt == NW'(1)) ? CHK : DAT_HI;
          end
          CHK: begin
            if (w_accept) begin
              r_sum       <= w_sum_next;
              r_tx_tvalid <= 1'b1;
              r_rx_tready <= 1'b0;
              r_state     <= RESP;
              if (w_sum_next == 8'h00) begin
                r_tx_tdata <= ACK_BYTE;
                r_err      <= 1'b0;
              end else begin
                r_tx_tdata <= NAK_BYTE;
                r_err      <= 1'b1;
              end
            end
          end
          RESP: begin
            if (r_tx_tvalid && bus.tx_tready) begin
              r_tx_tvalid <= 1'b0;
              r_busy      <= 1'b0;
              r_rx_tready <= 1'b1;
              r_state     <= IDLE;
              // The CPU is only released by a verified image.
              if (r_tx_tdata == ACK_BYTE) begin
                r_cpu_reset <= 1'b0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_tready = r_rx_tready;
  assign bus.tx_tvalid = r_tx_tvalid;
  assign bus.tx_tdata  = r_tx_tdata;
  assign rom_we_o      = r_rom_we;
  assign rom_adr_o     = r_rom_adr;
  assign rom_dat_o     = r_rom_dat;
  assign cpu_reset_o   = r_cpu_reset;
  assign busy_o        = r_busy;
  assign err_o         = r_err;
endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: frame vector table plus timeout, backpressure, noise and reset sequences.
module tb_rom_boot_loader;
  localparam int AW = 12;
  localparam int DW = 14;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_boot_loader_if u_if ();

  logic [AW-1:0] rom_adr_o;
  logic [DW-1:0] rom_dat_o;
  logic          rom_we_o;
  logic          cpu_reset_o;
  logic          busy_o;
  logic          err_o;

  rom_boot_loader #(
    .ROM_ADDR_WIDTH(AW),
    .ROM_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (u_if),
    .rom_adr_o  (rom_adr_o),
    .rom_dat_o  (rom_dat_o),
    .rom_we_o   (rom_we_o),
    .cpu_reset_o(cpu_reset_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ROM model fed from the write port
  int         wr_cnt = 0;
  int         dbl_we = 0;
  logic       prev_we = 1'b0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(negedge clk) begin
    if (rom_we_o === 1'b1) begin
      wr_cnt++;
      mem[rom_adr_o] = rom_dat_o;
      if (prev_we) dbl_we++;
    end
    prev_we = rom_we_o;
  end

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    logic [7:0]      resp;
    int              nwr;
    logic            err;
    logic            cpu;
    logic [DW-1:0]   w0;
    logic [DW-1:0]   w1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    u_if.rx_tdata  = b;
    u_if.rx_tvalid = 1'b1;
    while (!u_if.rx_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_accept_wait: rx_tready low for %0d cycles, expected accept", n);
    end
    @(negedge clk);
    u_if.rx_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [0:7][7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic get_resp(output logic [7:0] r);
    int n;
    n = 0;
    while (!u_if.tx_tvalid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_wait: no tx_tvalid after %0d cycles", n);
    end
    r = u_if.tx_tdata;
    u_if.tx_tready = 1'b1;
    @(negedge clk);
    u_if.tx_tready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_tready"}, 32'(u_if.rx_tready), 32'd1);
    chk({tag, "_tx_tvalid"}, 32'(u_if.tx_tvalid), 32'd0);
    chk({tag, "_tx_tdata"},  32'(u_if.tx_tdata),  32'd0);
    chk({tag, "_rom_we"},    32'(rom_we_o),       32'd0);
    chk({tag, "_rom_adr"},   32'(rom_adr_o),      32'd0);
    chk({tag, "_rom_dat"},   32'(rom_dat_o),      32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset_o),    32'd0);
    chk({tag, "_busy"},      32'(busy_o),         32'd0);
    chk({tag, "_err"},       32'(err_o),          32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] r;
  int         base;
  int         cnt;
  int         stable;

  initial begin
    vecs[0] = '{b: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h05, 8'h67, 8'h4C}, n: 8,
                resp: 8'h06, nwr: 2, err: 1'b0, cpu: 1'b0, w0: 14'h1234, w1: 14'h0567};
    vecs[1] = '{b: {8'hA5, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'h00}, n: 8,
                resp: 8'h15, nwr: 2, err: 1'b1, cpu: 1'b1, w0: 14'h0ABC, w1: 14'h0DEF};
    vecs[2] = '{b: {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h05, 8'h67, 8'h4C}, n: 8,
                resp: 8'h06, nwr: 2, err: 1'b0, cpu: 1'b0, w0: 14'h1234, w1: 14'h0567};
    vecs[3] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3,
                resp: 8'h15, nwr: 0, err: 1'b1, cpu: 1'b1, w0: 14'h0, w1: 14'h0};
    vecs[4] = '{b: {8'hA5, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3,
                resp: 8'h15, nwr: 0, err: 1'b1, cpu: 1'b1, w0: 14'h0, w1: 14'h0};
    vecs[5] = '{b: {8'hA5, 8'h00, 8'h01, 8'hFF, 8'hAB, 8'h55, 8'h00, 8'h00}, n: 6,
                resp: 8'h06, nwr: 1, err: 1'b0, cpu: 1'b0, w0: 14'h3FAB, w1: 14'h0};

    u_if.rx_tdata  = 8'h00;
    u_if.rx_tvalid = 1'b0;
    u_if.tx_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      base = wr_cnt;
      send_frame(vecs[v].b, vecs[v].n);
      chk($sformatf("v%0d_busy_in_frame", v), 32'(busy_o), 32'd1);
      chk($sformatf("v%0d_cpu_held", v), 32'(cpu_reset_o), 32'd1);
      get_resp(r);
      chk($sformatf("v%0d_resp", v), 32'(r), 32'(vecs[v].resp));
      chk($sformatf("v%0d_writes", v), 32'(wr_cnt - base), 32'(vecs[v].nwr));
      chk($sformatf("v%0d_err", v), 32'(err_o), 32'(vecs[v].err));
      chk($sformatf("v%0d_cpu_reset", v), 32'(cpu_reset_o), 32'(vecs[v].cpu));
      chk($sformatf("v%0d_busy_done", v), 32'(busy_o), 32'd0);
      if (vecs[v].nwr > 0) chk($sformatf("v%0d_rom0", v), 32'(mem[0]), 32'(vecs[v].w0));
      if (vecs[v].nwr > 1) chk($sformatf("v%0d_rom1", v), 32'(mem[1]), 32'(vecs[v].w1));
    end

    // Noise in IDLE after a NAK must not start a frame or release the CPU
    send_frame({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    get_resp(r);
    chk("noise_pre_nak", 32'(r), 32'h15);
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("noise_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("noise_busy", 32'(busy_o), 32'd0);
    chk("noise_tx_tvalid", 32'(u_if.tx_tvalid), 32'd0);
    send_frame({8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB9, 8'h00, 8'h00}, 6);
    get_resp(r);
    chk("noise_post_ack", 32'(r), 32'h06);
    chk("noise_post_cpu", 32'(cpu_reset_o), 32'd0);

    // Timeout after the data-high byte
    base = wr_cnt;
    send_frame({8'hA5, 8'h00, 8'h01, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    cnt = 0;
    while (!u_if.tx_tvalid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 32'(TO));
    chk("timeout_err", 32'(err_o), 32'd1);
    get_resp(r);
    chk("timeout_resp", 32'(r), 32'h15);
    chk("timeout_writes", 32'(wr_cnt - base), 32'd0);
    chk("timeout_cpu_reset", 32'(cpu_reset_o), 32'd1);

    // Response backpressure
    send_frame({8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB9, 8'h00, 8'h00}, 6);
    cnt = 0;
    while (!u_if.tx_tvalid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.tx_tvalid === 1'b1 && u_if.tx_tdata === 8'h06 && u_if.rx_tready === 1'b0) stable++;
      @(negedge clk);
    end
    chk("bp_stable_cycles", 32'(stable), 32'd20);
    get_resp(r);
    chk("bp_resp", 32'(r), 32'h06);
    chk("bp_cpu_reset", 32'(cpu_reset_o), 32'd0);

    // Reset during DAT_LO of a maximum-length (4096-word) frame
    send_frame({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    get_resp(r);
    send_frame({8'hA5, 8'h10, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    chk("max_len_no_nak", 32'(u_if.tx_tvalid), 32'd0);
    chk("max_len_busy", 32'(busy_o), 32'd1);
    chk("max_len_err_held", 32'(err_o), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    @(negedge clk);
    send_frame({8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB9, 8'h00, 8'h00}, 6);
    get_resp(r);
    chk("midrst_next_ack", 32'(r), 32'h06);

    chk("we_single_cycle", 32'(dbl_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
